control_frame_transmitter: RTL and testbench

Transmit side of the control-register transfer link. On request, it sends a framed control command one byte at a time: header 5A, C3, 7E, then the payload byte, then a trailer byte. This is the five-byte sequence the receiving control-register decoder consumes. Bytes leave over a four-phase VALID/ACK handshake to the link byte transmitter. A one-deep pending slot absorbs a request that arrives while a frame is in flight.

---
 rtl/control_frame_pkg.sv | 19 +
 rtl/control_frame_transmitter_handshake.sv | 64 ++++++
 rtl/control_frame_transmitter.sv | 131 +++++++++++++
 tb/tb_control_frame_transmitter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_frame_pkg.sv
// Shared definitions for the control-register frame link (transmitter and receiver).
// Frame layout: three header bytes, payload byte, trailer byte.
package control_frame_pkg;

   localparam logic [7:0] HDR_BYTE1_C    = 8'h5A;
   localparam logic [7:0] HDR_BYTE2_C    = 8'hC3;
   localparam logic [7:0] HDR_BYTE3_C    = 8'h7E;
   localparam logic [7:0] TRAILER_BYTE_C = 8'h00;

   localparam int         FRAME_LEN = 5;
   localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_REQ  = 2'd1,
      TX_REL  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/control_frame_transmitter_handshake.sv
// byte_handshake_tx: four-phase VALID/ACK engine for one byte at a time.
// Reports o_accepted in REL once ACK is low; i_next chains the following byte on the same edge.
module byte_handshake_tx
   import control_frame_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic i_start,
   input  logic i_next,
   input  logic i_ack,
   output logic o_valid,
   output logic o_idle,
   output logic o_accepted
);

   tx_state_t r_state;
   tx_state_t w_state_nxt;
   logic      r_valid;
   logic      w_valid_nxt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= TX_IDLE;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_valid;
      case (r_state)
         TX_IDLE: begin
            if (i_start) begin
               w_state_nxt = TX_REQ;
               w_valid_nxt = 1'b1;
            end
         end
         TX_REQ: begin
            if (i_ack) begin
               w_state_nxt = TX_REL;
               w_valid_nxt = 1'b0;
            end
         end
         TX_REL: begin
            if (!i_ack) begin
               w_state_nxt = i_next ? TX_REQ : TX_IDLE;
               w_valid_nxt = i_next;
            end
         end
         default: begin
            w_state_nxt = TX_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   assign o_valid    = r_valid;
   assign o_idle     = (r_state == TX_IDLE);
   assign o_accepted = (r_state == TX_REL) && !i_ack;

endmodule

// File: rtl/control_frame_transmitter.sv
// Frame sequencer: sends 5A C3 7E <payload> <trailer> over a four-phase link, with a one-deep pending slot.
// Define CONTROL_TX_CHECKSUM_EN to replace the trailer by the XOR of header bytes and payload.
module control_frame_transmitter
   import control_frame_pkg::*;
#(
   parameter logic [7:0] HDR_BYTE1    = HDR_BYTE1_C,
   parameter logic [7:0] HDR_BYTE2    = HDR_BYTE2_C,
   parameter logic [7:0] HDR_BYTE3    = HDR_BYTE3_C,
   parameter logic [7:0] TRAILER_BYTE = TRAILER_BYTE_C
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic       SEND,
   input  logic [7:0] PAYLOAD,
   input  logic       TRANSFER_OUT_ACK,
   output logic [7:0] TRANSFER_OUT_BYTE,
   output logic       TRANSFER_OUT_VALID,
   output logic       BUSY,
   output logic       DONE,
   output logic       OVERRUN
);

   logic       w_idle;
   logic       w_accepted;
   logic       w_launch;
   logic       w_next;
   logic [7:0] w_launch_payload;
   logic [7:0] w_byte4;
   logic [7:0] w_next_byte;

   logic [2:0] r_idx;
   logic [7:0] r_byte;
   logic       r_busy;
   logic       r_done;
   logic       r_overrun;
   logic       r_pend_vld;
   logic [7:0] r_pend_data;
   logic [7:0] r_payload;

   // The pending slot always has priority over a fresh SEND at launch.
   assign w_launch         = w_idle && !TRANSFER_OUT_ACK && (r_pend_vld || SEND);
   assign w_launch_payload = r_pend_vld ? r_pend_data : PAYLOAD;
   assign w_next           = w_accepted && (r_idx != LAST_IDX);

`ifdef CONTROL_TX_CHECKSUM_EN
   logic [7:0] r_checksum;

   always_ff @(posedge CLK) begin
      if (w_launch) begin
         r_checksum <= HDR_BYTE1 ^ HDR_BYTE2 ^ HDR_BYTE3 ^ w_launch_payload;
      end
   end

   assign w_byte4 = r_checksum;
`else
   assign w_byte4 = TRAILER_BYTE;
`endif

   always_comb begin
      w_next_byte = w_byte4;
      case (r_idx)
         3'd0:    w_next_byte = HDR_BYTE2;
         3'd1:    w_next_byte = HDR_BYTE3;
         3'd2:    w_next_byte = r_payload;
         default: w_next_byte = w_byte4;
      endcase
   end

   byte_handshake_tx u_handshake (
      .CLK        (CLK),
      .RST        (RST),
      .i_start    (w_launch),
      .i_next     (w_next),
      .i_ack      (TRANSFER_OUT_ACK),
      .o_valid    (TRANSFER_OUT_VALID),
      .o_idle     (w_idle),
      .o_accepted (w_accepted)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_idx      <= 3'd0;
         r_byte     <= 8'h00;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
         r_pend_vld <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_overrun <= 1'b0;

         if (w_launch) begin
            r_idx  <= 3'd0;
            r_byte <= HDR_BYTE1;
            r_busy <= 1'b1;
         end else if (w_next) begin
            r_idx  <= r_idx + 3'd1;
            r_byte <= w_next_byte;
         end else if (w_accepted) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
         end

         // A launch from the slot frees it, so a same-cycle SEND can refill it.
         if (w_launch && r_pend_vld) begin
            r_pend_vld <= SEND;
         end else if (SEND && !w_launch) begin
            if (r_pend_vld) begin
               r_overrun <= 1'b1;
            end else begin
               r_pend_vld <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_launch) begin
         r_payload <= w_launch_payload;
      end
      if (SEND && (!r_pend_vld || w_launch) && !(w_launch && !r_pend_vld)) begin
         r_pend_data <= PAYLOAD;
      end
   end

   assign TRANSFER_OUT_BYTE = r_byte;
   assign BUSY              = r_busy;
   assign DONE              = r_done;
   assign OVERRUN           = r_overrun;

endmodule

// File: tb/tb_control_frame_transmitter.sv
// Scoreboard bench for control_frame_transmitter: stimulus queues expected bytes, a monitor checks each offered byte.
module tb_control_frame_transmitter;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       SEND = 1'b0;
   logic [7:0] PAYLOAD = 8'h00;
   logic       link_ack = 1'b0;
   logic       force_ack = 1'b0;
   logic       TRANSFER_OUT_ACK;
   logic [7:0] TRANSFER_OUT_BYTE;
   logic       TRANSFER_OUT_VALID;
   logic       BUSY;
   logic       DONE;
   logic       OVERRUN;

   assign TRANSFER_OUT_ACK = link_ack | force_ack;

`ifdef CONTROL_TX_CHECKSUM_EN
   localparam bit CKS = 1'b1;
`else
   localparam bit CKS = 1'b0;
`endif

   control_frame_transmitter dut (
      .CLK                (CLK),
      .RST                (RST),
      .SEND               (SEND),
      .PAYLOAD            (PAYLOAD),
      .TRANSFER_OUT_ACK   (TRANSFER_OUT_ACK),
      .TRANSFER_OUT_BYTE  (TRANSFER_OUT_BYTE),
      .TRANSFER_OUT_VALID (TRANSFER_OUT_VALID),
      .BUSY               (BUSY),
      .DONE               (DONE),
      .OVERRUN            (OVERRUN)
   );

   always #5 CLK = ~CLK;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         rise_cnt = 0;
   int         done_cnt = 0;
   int         ovr_cnt = 0;

   function automatic logic [7:0] byte4(input logic [7:0] p);
      return CKS ? (8'h5A ^ 8'hC3 ^ 8'h7E ^ p) : 8'h00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] p);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'h7E);
      exp_q.push_back(p);
      exp_q.push_back(byte4(p));
   endtask

   // Called #1 after a rising edge; SEND is sampled at the next edge.
   task automatic send(input logic [7:0] p, input bit expect_frame);
      SEND    = 1'b1;
      PAYLOAD = p;
      if (expect_frame) push_frame(p);
      @(posedge CLK);
      #1;
      SEND    = 1'b0;
      PAYLOAD = 8'hFF;
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt >= target) break;
         @(posedge CLK);
      end
      repeat (3) @(posedge CLK);
      #1;
      check({name, "_done"}, done_cnt, target);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_busy_low"}, BUSY, 1'b0);
   endtask

   // Link model: raise ACK two cycles after VALID, drop it two cycles after VALID falls.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (!RST) begin
            link_ack = 1'b0;
            cnt = 0;
         end else if ((TRANSFER_OUT_VALID && !link_ack) || (!TRANSFER_OUT_VALID && link_ack)) begin
            cnt++;
            if (cnt >= 2) begin
               link_ack = ~link_ack;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor
   logic       prev_v = 1'b0;
   logic [7:0] held = 8'h00;
   always @(negedge CLK) begin
      if (!RST) begin
         prev_v = 1'b0;
      end else begin
         if (TRANSFER_OUT_VALID && !prev_v) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_byte", 32'(TRANSFER_OUT_BYTE), 32'hFFFF_FFFF);
            end else begin
               check("frame_byte", TRANSFER_OUT_BYTE, exp_q.pop_front());
            end
            check("busy_during_valid", BUSY, 1'b1);
            held = TRANSFER_OUT_BYTE;
         end else if (TRANSFER_OUT_VALID) begin
            check("byte_stable", TRANSFER_OUT_BYTE, held);
         end
         if (DONE) done_cnt++;
         if (OVERRUN) ovr_cnt++;
         prev_v = TRANSFER_OUT_VALID;
      end
   end

   initial begin
      int base;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_valid", TRANSFER_OUT_VALID, 1'b0);
      check("rst_byte", TRANSFER_OUT_BYTE, 8'h00);
      check("rst_busy", BUSY, 1'b0);
      check("rst_done", DONE, 1'b0);
      check("rst_overrun", OVERRUN, 1'b0);
      RST = 1'b1;
      @(posedge CLK);
      #1;

      // Single frame
      send(8'h3C, 1'b1);
      check("launch_latency", TRANSFER_OUT_VALID, 1'b1);
      check("launch_busy", BUSY, 1'b1);
      wait_done(1, "single");

      // Second request lands in the pending slot
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      wait_done(3, "pending");
      check("pending_no_overrun", ovr_cnt, 0);

      // Third request while busy with slot full is dropped
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      send(8'h33, 1'b0);
      wait_done(5, "overrun");
      check("overrun_pulses", ovr_cnt, 1);

      // ACK stuck high blocks launch
      force_ack = 1'b1;
      @(posedge CLK);
      #1;
      send(8'h55, 1'b1);
      repeat (5) @(posedge CLK);
      #1;
      check("ack_stuck_valid_low", TRANSFER_OUT_VALID, 1'b0);
      check("ack_stuck_busy_low", BUSY, 1'b0);
      force_ack = 1'b0;
      wait_done(6, "ack_stuck");

      // Reset during the payload byte, with a request waiting in the slot
      base = rise_cnt;
      send(8'hAA, 1'b1);
      send(8'hBB, 1'b1);
      for (int i = 0; i < 200; i++) begin
         if (rise_cnt >= base + 4) break;
         @(negedge CLK);
      end
      check("reached_payload_byte", rise_cnt, base + 4);
      #2;
      RST = 1'b0;
      #1;
      check("midrst_valid", TRANSFER_OUT_VALID, 1'b0);
      check("midrst_busy", BUSY, 1'b0);
      check("midrst_byte", TRANSFER_OUT_BYTE, 8'h00);
      check("midrst_remaining", exp_q.size(), 6);
      exp_q.delete();
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check("no_stale_frame", TRANSFER_OUT_VALID, 1'b0);
      check("no_done_after_abort", done_cnt, 6);
      send(8'h77, 1'b1);
      wait_done(7, "after_reset");

      // Payload whose trailer differs when the checksum is enabled
      send(8'hA5, 1'b1);
      wait_done(8, "a5_frame");
      check("final_overrun_count", ovr_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
